// File: rtl/conv_param_seq_pkg.sv
// Shared types and constants for the conv parameter sequencer.
// Parameter memory is organised as four banks per filter: three weight banks and one bias bank.
package conv_param_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RB_RD,
        ST_RB_OUT,
        ST_STREAM
    } state_t;

    localparam int unsigned BANK_BW = 2;

    localparam logic [BANK_BW-1:0] BANK_W0   = 2'd0;
    localparam logic [BANK_BW-1:0] BANK_W1   = 2'd1;
    localparam logic [BANK_BW-1:0] BANK_W2   = 2'd2;
    localparam logic [BANK_BW-1:0] BANK_BIAS = 2'd3;

    // Bias value lives in the low bits of a parameter word.
    localparam int unsigned BIAS_BW = 32;

endpackage

// File: rtl/conv_param_seq_counter.sv
// seq_counter: walks (addr, bank) in addr-major, bank-minor order.
// Shared by the load and readback paths; last_o marks the final bias word.
module seq_counter
    import conv_param_seq_pkg::*;
#(
    parameter int unsigned NUM_FILTERS = 8,
    parameter int unsigned ADDR_BW     = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               adv_i,
    output logic [ADDR_BW-1:0] addr_o,
    output logic [BANK_BW-1:0] bank_o,
    output logic               last_o
);

    logic [ADDR_BW-1:0] r_addr;
    logic [BANK_BW-1:0] r_bank;
    logic [BANK_BW-1:0] w_bank_nxt;
    logic               w_addr_last;

    assign w_addr_last = (r_addr == ADDR_BW'(NUM_FILTERS - 1));

    always_comb begin
        w_bank_nxt = BANK_W0;
        case (r_bank)
            BANK_W0: w_bank_nxt = BANK_W1;
            BANK_W1: w_bank_nxt = BANK_W2;
            BANK_W2: w_bank_nxt = BANK_BIAS;
            default: w_bank_nxt = BANK_W0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_addr <= '0;
            r_bank <= BANK_W0;
        end else if (adv_i) begin
            r_bank <= w_bank_nxt;
            if (r_bank == BANK_BIAS) begin
                r_addr <= w_addr_last ? '0 : r_addr + ADDR_BW'(1);
            end
        end
    end

    assign addr_o = r_addr;
    assign bank_o = r_bank;
    assign last_o = w_addr_last && (r_bank == BANK_BIAS);

endmodule

// File: rtl/conv_param_seq.sv
// Conv parameter sequencer: loads/reads back the parameter memory and gates
// feature vectors into the conv datapath in FRAME_LEN-sized frames.
module conv_param_seq
    import conv_param_seq_pkg::*;
#(
    parameter int unsigned  FRAME_LEN   = 50,
    parameter int unsigned  COLUMN_LEN  = 13,
    parameter int unsigned  NUM_FILTERS = 8,
    localparam int unsigned VECTOR_BW   = COLUMN_LEN * 8,
    localparam int unsigned ADDR_BW     = $clog2(NUM_FILTERS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_start_i,
    input  logic                 readback_start_i,
    input  logic                 stream_en_i,
    input  logic [VECTOR_BW-1:0] cfg_data_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    output logic [VECTOR_BW-1:0] rb_data_o,
    output logic                 rb_valid_o,
    input  logic                 rb_ready_i,
    output logic                 mem_rd_en_o,
    output logic                 mem_wr_en_o,
    output logic [BANK_BW-1:0]   mem_bank_o,
    output logic [ADDR_BW-1:0]   mem_addr_o,
    output logic [VECTOR_BW-1:0] mem_wr_data_o,
    input  logic [VECTOR_BW-1:0] mem_rd_data_i,
    input  logic                 feat_valid_i,
    output logic                 feat_ready_o,
    output logic                 conv_valid_o,
    output logic                 conv_last_o,
    input  logic                 conv_ready_i,
    output logic                 loaded_o,
    output logic                 busy_o
);

    localparam int unsigned FRAME_BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    if (VECTOR_BW < BIAS_BW) begin : g_width_chk
        $error("parameter word narrower than bias field");
    end

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_loaded;
    logic [FRAME_BW-1:0]  r_frame;
    logic [FRAME_BW-1:0]  w_frame_nxt;
    logic [VECTOR_BW-1:0] r_rb_hold;
    logic                 r_hold_vld;

    logic                 w_cnt_clr;
    logic                 w_cnt_adv;
    logic                 w_cnt_last;
    logic [ADDR_BW-1:0]   w_addr;
    logic [BANK_BW-1:0]   w_bank;
    logic                 w_conv_hs;
    logic                 w_frame_last;

    seq_counter #(
        .NUM_FILTERS (NUM_FILTERS),
        .ADDR_BW     (ADDR_BW)
    ) u_seq_counter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (w_cnt_clr),
        .adv_i  (w_cnt_adv),
        .addr_o (w_addr),
        .bank_o (w_bank),
        .last_o (w_cnt_last)
    );

    assign w_conv_hs    = (r_state == ST_STREAM) && feat_valid_i && conv_ready_i;
    assign w_frame_last = (r_frame == FRAME_BW'(FRAME_LEN - 1));

    always_comb begin
        w_frame_nxt = r_frame;
        if (w_conv_hs) begin
            w_frame_nxt = w_frame_last ? '0 : r_frame + FRAME_BW'(1);
        end
    end

    // Next-state and handshake decode; stream exit waits for the frame boundary.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_clr     = 1'b0;
        w_cnt_adv     = 1'b0;
        cfg_ready_o   = 1'b0;
        mem_wr_en_o   = 1'b0;
        mem_rd_en_o   = 1'b0;
        mem_wr_data_o = '0;
        rb_valid_o    = 1'b0;
        feat_ready_o  = 1'b0;
        conv_valid_o  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_start_i) begin
                    w_state_nxt = ST_LOAD;
                    w_cnt_clr   = 1'b1;
                end else if (readback_start_i) begin
                    w_state_nxt = ST_RB_RD;
                    w_cnt_clr   = 1'b1;
                end else if (stream_en_i && r_loaded) begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_LOAD: begin
                cfg_ready_o   = 1'b1;
                mem_wr_en_o   = cfg_valid_i;
                mem_wr_data_o = cfg_data_i;
                w_cnt_adv     = cfg_valid_i;
                if (cfg_valid_i && w_cnt_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RB_RD: begin
                mem_rd_en_o = 1'b1;
                w_state_nxt = ST_RB_OUT;
            end
            ST_RB_OUT: begin
                rb_valid_o = r_hold_vld;
                if (r_hold_vld && rb_ready_i) begin
                    w_cnt_adv   = 1'b1;
                    w_state_nxt = w_cnt_last ? ST_IDLE : ST_RB_RD;
                end
            end
            ST_STREAM: begin
                feat_ready_o = conv_ready_i;
                conv_valid_o = feat_valid_i;
                if (!stream_en_i && (w_frame_nxt == '0)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_loaded   <= 1'b0;
            r_frame    <= '0;
            r_hold_vld <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_frame    <= w_frame_nxt;
            r_hold_vld <= (r_state == ST_RB_OUT) && !(r_hold_vld && rb_ready_i);
            if ((r_state == ST_IDLE) && load_start_i) begin
                r_loaded <= 1'b0;
            end else if ((r_state == ST_LOAD) && cfg_valid_i && w_cnt_last) begin
                r_loaded <= 1'b1;
            end
        end
    end

    // Memory data arrives the cycle after the read strobe; latch it once per word.
    always_ff @(posedge clk_i) begin
        if ((r_state == ST_RB_OUT) && !r_hold_vld) begin
            r_rb_hold <= mem_rd_data_i;
        end
    end

    assign rb_data_o   = r_rb_hold;
    assign mem_bank_o  = w_bank;
    assign mem_addr_o  = w_addr;
    assign conv_last_o = conv_valid_o && w_frame_last;
    assign loaded_o    = r_loaded;
    assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: doc/conv_param_seq.md
CONV_PARAM_SEQ -- requirements
Module: conv_param_seq

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 50: input vectors per frame.
REQ-002 The block SHALL have parameter COLUMN_LEN, default 13: elements per input vector.
REQ-003 The block SHALL have parameter NUM_FILTERS, default 8: filter count, which is also the parameter-memory depth.
REQ-004 The block SHALL define local VECTOR_BW = COLUMN_LEN*8, ADDR_BW = $clog2(NUM_FILTERS) and BANK_BW = 2, with banks 0..2 holding weights and bank 3 holding bias.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have ports load_start_i and readback_start_i, inputs, 1 bit each: single-cycle command pulses.
REQ-008 The block SHALL have port stream_en_i, input, 1 bit: level request to stream features.
REQ-009 The block SHALL have ports cfg_data_i (input, VECTOR_BW), cfg_valid_i (input, 1) and cfg_ready_o (output, 1): the parameter word stream.
REQ-010 The block SHALL have ports rb_data_o (output, VECTOR_BW), rb_valid_o (output, 1) and rb_ready_i (input, 1): the readback stream.
REQ-011 The block SHALL have ports mem_rd_en_o (output, 1), mem_wr_en_o (output, 1), mem_bank_o (output, BANK_BW), mem_addr_o (output, ADDR_BW), mem_wr_data_o (output, VECTOR_BW) and mem_rd_data_i (input, VECTOR_BW): the conv parameter-memory port.
REQ-012 The block SHALL have ports feat_valid_i (input, 1) and feat_ready_o (output, 1): the upstream feature handshake.
REQ-013 The block SHALL have ports conv_valid_o (output, 1), conv_last_o (output, 1) and conv_ready_i (input, 1): the conv datapath handshake. Feature data bypasses this block.
REQ-014 The block SHALL have ports loaded_o and busy_o, outputs, 1 bit each: status.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, RB_RD, RB_OUT and STREAM.
REQ-016 In IDLE, command priority SHALL be load_start_i > readback_start_i > (stream_en_i & loaded_o); the highest-priority active command is taken the next cycle.
REQ-017 Entering LOAD SHALL clear loaded_o and the addr/bank counters.
REQ-018 In LOAD, cfg_ready_o SHALL be 1, and mem_wr_en_o SHALL equal cfg_valid_i combinationally.
REQ-019 In LOAD, mem_bank_o/mem_addr_o SHALL equal the counters and mem_wr_data_o SHALL equal cfg_data_i.
REQ-020 Word order SHALL be addr-major, bank-minor: (a0,b0..b3), (a1,b0..b3), ...
REQ-021 Bias words SHALL occupy bits [31:0], with upper bits written as supplied.
REQ-022 After the 4*NUM_FILTERS-th accepted word, the block SHALL set loaded_o=1 next cycle and return to IDLE.
REQ-023 cfg_valid_i gaps SHALL stall LOAD without timeout.
REQ-024 Readback SHALL walk the same order as REQ-020.
REQ-025 In RB_RD, mem_rd_en_o SHALL be 1 for exactly one cycle; memory read latency is 1 cycle.
REQ-026 mem_rd_data_i SHALL be captured into a holding register the following cycle, which enters RB_OUT.
REQ-027 In RB_OUT, rb_valid_o SHALL be 1 with rb_data_o stable until rb_ready_i; on handshake the counter advances to RB_RD, or to IDLE after the last word.
REQ-028 In STREAM, feat_ready_o SHALL equal conv_ready_i, conv_valid_o SHALL equal feat_valid_i, and both SHALL be 0 in all other states.
REQ-029 A frame counter 0..FRAME_LEN-1 SHALL increment on each conv_valid_o&conv_ready_i and wrap to 0.
REQ-030 conv_last_o SHALL be 1 when the counter is FRAME_LEN-1 and conv_valid_o is 1.
REQ-031 STREAM SHALL exit to IDLE only when stream_en_i=0 and the frame counter is 0; deassertion mid-frame finishes the frame first.
REQ-032 load_start_i and readback_start_i outside IDLE SHALL be ignored and not queued.
REQ-033 mem_wr_en_o and mem_rd_en_o SHALL never both be 1.
REQ-034 busy_o SHALL be 1 in every state except IDLE.

Reset
REQ-035 While rst_i=1 at a clock edge, the state SHALL become IDLE and all counters 0.
REQ-036 After reset, loaded_o=0 and all valid/ready/enable outputs SHALL be 0.
REQ-037 A mid-operation reset SHALL abandon the load or readback, leaving loaded_o=0.
REQ-038 The readback holding register SHALL need no reset.

Structure
REQ-039 A shared package SHALL hold the state enum, the bank index constants (W0=0, W1=1, W2=2, BIAS=3) and the bias width of 32.
REQ-040 One sub-module, seq_counter (addr/bank walker with a last flag), SHALL be shared by the LOAD and readback paths.

Verification
REQ-041 Reset, then load 32 words 0..31 with cfg_valid held high -> 32 consecutive mem_wr_en_o pulses, bank cycling 0,1,2,3 and addr 0..7; loaded_o=1 on cycle 33.
REQ-042 Load with cfg_valid_i toggling every other cycle -> exactly 32 writes, correct addr/bank, no duplicate write.
REQ-043 Readback after load with rb_ready_i low for 3 cycles per word -> 32 words equal to 0..31, rb_data_o stable while stalled.
REQ-044 stream_en_i=1 with 120 feature vectors, then stream_en_i=0 at vector 60 -> conv_last_o pulses on vectors 50 and 100; exit to IDLE after vector 100 and no ready thereafter.
REQ-045 Pulse rst_i during LOAD after 10 words -> IDLE, loaded_o=0; a subsequent stream_en_i is refused.
REQ-046 load_start_i during STREAM, and simultaneous load/readback/stream in IDLE -> STREAM ignores the command; IDLE enters LOAD.
